// File: rtl/day3_host_link.sv
// day3 host link: frames one solver job over ua_tx and
// collects the 8-byte big-endian result from ua_rx.
module day3_host_link #(
  parameter int MAX_LINE_BYTES = 50,
  parameter int TIMEOUT_CYCLES = 100_000_000
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  line_len,
  input  logic [11:0] n_lines,
  input  logic [3:0]  n_digits,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [7:0]  tx_data,
  output logic        tx_xmit,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_recd,
  output logic        rx_rst,
  output logic        busy,
  output logic [63:0] result,
  output logic        result_valid,
  output logic        error
);

  localparam logic [8:0]  MAX_LL  = 9'(MAX_LINE_BYTES);
  localparam logic [31:0] TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LINE, S_RESP, S_ERR
  } state_t;

  typedef enum logic [1:0] {
    T_IDLE, T_WAIT, T_XMIT
  } tx_state_t;

  state_t      state;
  tx_state_t   tst;
  logic [7:0]  ll_q;
  logic [11:0] nl_q;
  logic [3:0]  nd_q;
  logic [19:0] total;
  logic [19:0] sent;
  logic [2:0]  hdr_idx;
  logic [63:0] acc;
  logic [2:0]  rcnt;
  logic [31:0] wd;

  logic [8:0]  two_ll;
  logic        bad_job;
  logic [19:0] prod;
  logic [7:0]  hdr_byte;
  logic        ld_hdr;
  logic        ld_line;
  logic        ld;
  logic [7:0]  ld_byte;
  logic [63:0] acc_nxt;

  assign two_ll  = {line_len, 1'b0};
  assign bad_job = (line_len == 8'd0)
                || ({1'b0, line_len} > MAX_LL)
                || (n_digits == 4'd0)
                || ({5'b0, n_digits} > two_ll);
  assign prod    = 20'(line_len) * 20'(n_lines);
  assign acc_nxt = {acc[55:0], rx_data};

  // A line byte is taken only when no byte is in flight to ua_tx
  assign s_ready = (state == S_LINE)
                && (tst == T_IDLE)
                && (sent != total);

  assign ld_hdr  = (state == S_HDR)
                && (tst == T_IDLE)
                && (hdr_idx != 3'd4);
  assign ld_line = s_valid && s_ready;
  assign ld      = ld_hdr || ld_line;
  assign ld_byte = ld_hdr ? hdr_byte : s_data;

  // Header byte selected by send position
  always_comb begin
    hdr_byte = 8'h00;
    unique case (1'b1)
      (hdr_idx == 3'd0): hdr_byte = 8'hAA;
      (hdr_idx == 3'd1): hdr_byte = ll_q;
      (hdr_idx == 3'd2): hdr_byte = nl_q[11:4];
      default:           hdr_byte = {nl_q[3:0], nd_q};
    endcase
  end

  // Job FSM, tx handshake and response collection
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state        <= S_IDLE;
      tst          <= T_IDLE;
      ll_q         <= 8'd0;
      nl_q         <= 12'd0;
      nd_q         <= 4'd0;
      total        <= 20'd0;
      sent         <= 20'd0;
      hdr_idx      <= 3'd0;
      acc          <= 64'd0;
      rcnt         <= 3'd0;
      wd           <= 32'd0;
      tx_data      <= 8'd0;
      tx_xmit      <= 1'b0;
      rx_rst       <= 1'b1;
      busy         <= 1'b0;
      result       <= 64'd0;
      result_valid <= 1'b0;
      error        <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      rx_rst       <= 1'b0;

      unique case (tst)
        T_IDLE: begin
          if (ld) begin
            tx_data <= ld_byte;
            if (tx_ready) begin
              tx_xmit <= 1'b1;
              tst     <= T_XMIT;
            end else begin
              tst <= T_WAIT;
            end
          end
        end
        T_WAIT: begin
          if (tx_ready) begin
            tx_xmit <= 1'b1;
            tst     <= T_XMIT;
          end
        end
        T_XMIT: begin
          if (!tx_ready) begin
            tx_xmit <= 1'b0;
            tst     <= T_IDLE;
          end
        end
        default: tst <= T_IDLE;
      endcase

      unique case (state)
        S_IDLE: begin
          if (start) begin
            if (bad_job) begin
              error <= 1'b1;
              state <= S_ERR;
            end else begin
              ll_q    <= line_len;
              nl_q    <= n_lines;
              nd_q    <= n_digits;
              total   <= prod;
              sent    <= 20'd0;
              hdr_idx <= 3'd0;
              error   <= 1'b0;
              busy    <= 1'b1;
              state   <= S_HDR;
            end
          end
        end
        S_HDR: begin
          if (ld_hdr) begin
            hdr_idx <= hdr_idx + 3'd1;
          end else if (hdr_idx == 3'd4 && tst == T_IDLE) begin
            state <= S_LINE;
          end
        end
        S_LINE: begin
          if (ld_line) begin
            sent <= sent + 20'd1;
          end else if (sent == total && tst == T_IDLE) begin
            wd    <= 32'd0;
            rcnt  <= 3'd0;
            state <= S_RESP;
          end
        end
        S_RESP: begin
          if (rx_recd && !rx_rst) begin
            acc    <= acc_nxt;
            rcnt   <= rcnt + 3'd1;
            rx_rst <= 1'b1;
            wd     <= 32'd0;
            if (rcnt == 3'd7) begin
              result       <= acc_nxt;
              result_valid <= 1'b1;
              busy         <= 1'b0;
              state        <= S_IDLE;
            end
          end else if (wd == TO_LAST) begin
            error <= 1'b1;
            busy  <= 1'b0;
            state <= S_ERR;
          end else begin
            wd <= wd + 32'd1;
          end
        end
        S_ERR: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_day3_host_link.sv
// Scoreboard bench for day3_host_link with ua_tx/ua_rx
// behavioural models and a randomized job mix.
module tb_day3_host_link;

  localparam int TO = 1000;

  logic        sysclk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  line_len = 8'd0;
  logic [11:0] n_lines = 12'd0;
  logic [3:0]  n_digits = 4'd0;
  logic [7:0]  s_data = 8'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  tx_data;
  logic        tx_xmit;
  logic        tx_ready = 1'b1;
  logic [7:0]  rx_data = 8'd0;
  logic        rx_recd = 1'b0;
  logic        rx_rst;
  logic        busy;
  logic [63:0] result;
  logic        result_valid;
  logic        error;

  always #5 sysclk = ~sysclk;

  day3_host_link #(
    .MAX_LINE_BYTES(50),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .sysclk(sysclk),
    .reset(reset),
    .start(start),
    .line_len(line_len),
    .n_lines(n_lines),
    .n_digits(n_digits),
    .s_data(s_data),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .tx_data(tx_data),
    .tx_xmit(tx_xmit),
    .tx_ready(tx_ready),
    .rx_data(rx_data),
    .rx_recd(rx_recd),
    .rx_rst(rx_rst),
    .busy(busy),
    .result(result),
    .result_valid(result_valid),
    .error(error)
  );

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int tx_cnt = 0;
  int tx_busy = 3;
  int src_gap = 0;
  int src_acc = 0;
  int ovl = 0;
  int last_ack = 0;
  bit src_abort = 1'b0;
  logic [63:0] last_res = 64'd0;

  logic [7:0]  exp_tx[$];
  logic [7:0]  src_q[$];
  logic [7:0]  lb_q[$];
  logic [63:0] exp_res[$];

  always @(posedge sysclk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic bit job_ok(input logic [7:0] ll,
                                input logic [3:0] nd);
    return (ll != 0) && (int'(ll) <= 50) && (nd != 0)
        && (int'(nd) <= 2 * int'(ll));
  endfunction

  // ua_tx model: takes a byte on xmit, stays busy for tx_busy cycles
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge sysclk);
      if (tx_xmit && tx_ready) begin
        tx_cnt++;
        if (exp_tx.size() == 0) begin
          chk(1'b0, "tx_unexpected", 64'(tx_data), 64'd0);
        end else begin
          e = exp_tx.pop_front();
          chk(tx_data == e, "tx_byte", 64'(tx_data), 64'(e));
        end
        tx_ready = 1'b0;
        repeat (tx_busy) @(negedge sysclk);
        tx_ready = 1'b1;
      end
    end
  end

  always @(negedge sysclk) begin
    if (s_ready && tx_xmit) ovl <= ovl + 1;
  end

  // result monitor
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge sysclk);
      if (result_valid) begin
        if (exp_res.size() == 0) begin
          chk(1'b0, "result_unexpected", result, 64'd0);
        end else begin
          e = exp_res.pop_front();
          chk(result == e, "result", result, e);
          chk(busy == 1'b0, "busy_after_result", 64'(busy), 64'd0);
        end
      end
    end
  end

  // line byte source
  initial begin
    int gap;
    gap = 0;
    forever begin
      @(posedge sysclk);
      #1;
      if (src_abort) begin
        src_q.delete();
        s_valid = 1'b0;
        gap = 0;
      end else if (src_q.size() == 0) begin
        s_valid = 1'b0;
      end else if (gap > 0) begin
        s_valid = 1'b0;
        gap--;
      end else begin
        s_valid = 1'b1;
        s_data = src_q[0];
        @(negedge sysclk);
        if (s_ready) begin
          void'(src_q.pop_front());
          src_acc++;
          gap = src_gap;
        end
      end
    end
  end

  task automatic issue_start(input logic [7:0] ll,
                             input logic [11:0] nl,
                             input logic [3:0] nd);
    @(posedge sysclk);
    #1;
    line_len = ll;
    n_lines = nl;
    n_digits = nd;
    start = 1'b1;
    @(posedge sysclk);
    #1;
    start = 1'b0;
  endtask

  task automatic respond(input logic [63:0] v, input int n);
    for (int i = 0; i < n; i++) begin
      int k;
      bit got;
      repeat ($urandom_range(1, 20)) @(posedge sysclk);
      #1;
      rx_data = v[63 - 8 * i -: 8];
      rx_recd = 1'b1;
      got = 1'b0;
      k = 0;
      while (!got && k < 200) begin
        @(negedge sysclk);
        if (rx_rst) begin
          got = 1'b1;
          last_ack = cyc;
        end
        k++;
      end
      if (!got) chk(1'b0, "rx_ack_timeout", 64'd0, 64'd1);
      @(posedge sysclk);
      #1;
      rx_recd = 1'b0;
    end
  endtask

  task automatic wait_tx_done(input int budget);
    int k;
    k = 0;
    while ((exp_tx.size() != 0 || !tx_ready || tx_xmit)
           && k < budget) begin
      @(negedge sysclk);
      k++;
    end
    if (k >= budget)
      chk(1'b0, "tx_done_timeout", 64'(exp_tx.size()), 64'd0);
  endtask

  task automatic push_hdr(input logic [7:0] ll,
                          input logic [11:0] nl,
                          input logic [3:0] nd);
    exp_tx.push_back(8'hAA);
    exp_tx.push_back(ll);
    exp_tx.push_back(nl[11:4]);
    exp_tx.push_back({nl[3:0], nd});
  endtask

  task automatic run_job(input logic [7:0] ll,
                         input logic [11:0] nl,
                         input logic [3:0] nd,
                         input int gap,
                         input logic [63:0] resp,
                         input int nresp);
    int n0, nb, k;
    bit rdy;
    n0 = tx_cnt;
    nb = int'(ll) * int'(nl);
    push_hdr(ll, nl, nd);
    if (lb_q.size() == 0)
      for (int i = 0; i < nb; i++) lb_q.push_back(8'($urandom));
    foreach (lb_q[i]) exp_tx.push_back(lb_q[i]);
    src_gap = gap;
    src_q = lb_q;
    lb_q.delete();
    rdy = tx_ready;
    issue_start(ll, nl, nd);
    @(negedge sysclk);
    chk(busy == 1'b1, "busy_set", 64'(busy), 64'd1);
    chk(error == 1'b0, "error_clear", 64'(error), 64'd0);
    @(negedge sysclk);
    if (rdy) chk(tx_xmit == 1'b1, "first_xmit", 64'(tx_xmit), 64'd1);
    wait_tx_done((nb + 4) * (tx_busy + gap + 10) + 200);
    chk(tx_cnt - n0 == 4 + nb, "tx_count",
        64'(tx_cnt - n0), 64'(4 + nb));
    if (nresp == 8) begin
      exp_res.push_back(resp);
      last_res = resp;
    end
    respond(resp, nresp);
    if (nresp == 8) begin
      k = 0;
      while (busy && k < 100) begin
        @(negedge sysclk);
        k++;
      end
      repeat (2) @(negedge sysclk);
      chk(exp_res.size() == 0, "result_delivered",
          64'(exp_res.size()), 64'd0);
    end
  endtask

  task automatic bad_start(input logic [7:0] ll,
                           input logic [11:0] nl,
                           input logic [3:0] nd);
    int n0;
    n0 = tx_cnt;
    issue_start(ll, nl, nd);
    @(negedge sysclk);
    chk(error == 1'b1, "error_set", 64'(error), 64'd1);
    chk(busy == 1'b0, "busy_low_err", 64'(busy), 64'd0);
    repeat (10) @(negedge sysclk);
    chk(tx_cnt == n0, "no_tx_on_err", 64'(tx_cnt - n0), 64'd0);
    chk(error == 1'b1, "error_sticky", 64'(error), 64'd1);
  endtask

  task automatic check_reset_vals();
    chk(s_ready == 1'b0, "rst_s_ready", 64'(s_ready), 64'd0);
    chk(tx_xmit == 1'b0, "rst_tx_xmit", 64'(tx_xmit), 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(result_valid == 1'b0, "rst_rv", 64'(result_valid), 64'd0);
    chk(error == 1'b0, "rst_error", 64'(error), 64'd0);
    chk(rx_rst == 1'b1, "rst_rx_rst", 64'(rx_rst), 64'd1);
    chk(tx_data == 8'd0, "rst_tx_data", 64'(tx_data), 64'd0);
    chk(result == 64'd0, "rst_result", result, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge sysclk);
    #1;
    reset = 1'b1;
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    exp_tx.delete();
    last_res = 64'd0;
    @(negedge sysclk);
    check_reset_vals();
    src_abort = 1'b0;
    src_q.delete();
  endtask

  task automatic wait_src(input int target, input string nm);
    int k;
    k = 0;
    while (src_acc < target && k < 2000) begin
      @(negedge sysclk);
      k++;
    end
    if (src_acc < target)
      chk(1'b0, nm, 64'(src_acc), 64'(target));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got none expected finish");
    $fatal(1);
  end

  initial begin
    int n0, base, k, t0;
    logic [7:0] ll;
    logic [3:0] nd;
    logic [11:0] nl;

    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    check_reset_vals();
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    repeat (3) @(posedge sysclk);

    // nominal job
    lb_q = '{8'h98, 8'h76, 8'h12, 8'h34};
    run_job(8'd2, 12'd2, 4'd2, 0, 64'h00000000000000C6, 8);

    // stalled source and slow transmitter
    tx_busy = 300;
    lb_q = '{8'h98, 8'h76, 8'h12, 8'h34};
    run_job(8'd2, 12'd2, 4'd2, 50, 64'h0123456789ABCDEF, 8);
    tx_busy = 3;

    // invalid parameters, then a valid job clears error
    bad_start(8'd51, 12'd1, 4'd1);
    bad_start(8'd2, 12'd1, 4'd5);
    bad_start(8'd0, 12'd1, 4'd1);
    bad_start(8'd3, 12'd1, 4'd0);
    bad_start(8'd1, 12'd1, 4'd3);
    run_job(8'd1, 12'd1, 4'd2, 0, {$urandom, $urandom}, 8);
    run_job(8'd50, 12'd1, 4'd15, 0, {$urandom, $urandom}, 8);

    // header-only job
    run_job(8'd3, 12'd0, 4'd6, 0, 64'd0, 8);

    // response timeout after 3 bytes
    run_job(8'd1, 12'd2, 4'd1, 0, 64'hDEADBEEFCAFEF00D, 3);
    t0 = last_ack;
    k = 0;
    while (!error && k < TO + 100) begin
      @(negedge sysclk);
      k++;
    end
    if (error) chk(cyc - t0 == TO, "timeout_cycles",
                   64'(cyc - t0), 64'(TO));
    else chk(1'b0, "timeout_missing", 64'(error), 64'd1);
    chk(result == last_res, "result_kept", result, last_res);
    repeat (3) @(negedge sysclk);
    chk(busy == 1'b0, "busy_after_timeout", 64'(busy), 64'd0);

    // reset in the middle of the line stream
    n0 = tx_cnt;
    base = src_acc;
    push_hdr(8'd2, 12'd3, 4'd3);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_tx.push_back(b);
      src_q.push_back(b);
    end
    src_gap = 0;
    issue_start(8'd2, 12'd3, 4'd3);
    wait_src(base + 5, "src_5th_byte");
    k = 0;
    while (tx_cnt - n0 < 9 && k < 200) begin
      @(negedge sysclk);
      k++;
    end
    src_abort = 1'b1;
    do_reset();
    repeat (20) @(negedge sysclk);
    chk(tx_cnt - n0 == 9, "no_tx_after_reset",
        64'(tx_cnt - n0), 64'd9);
    run_job(8'd2, 12'd1, 4'd4, 1, {$urandom, $urandom}, 8);

    // edge values, start while busy is ignored
    n0 = tx_cnt;
    base = src_acc;
    push_hdr(8'd50, 12'hFFF, 4'd15);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'($urandom);
      exp_tx.push_back(b);
      src_q.push_back(b);
    end
    src_gap = 0;
    issue_start(8'd50, 12'hFFF, 4'd15);
    wait_src(base + 5, "edge_src");
    issue_start(8'd1, 12'd1, 4'd1);
    @(negedge sysclk);
    chk(busy == 1'b1, "busy_hold", 64'(busy), 64'd1);
    wait_tx_done(500);
    chk(tx_cnt - n0 == 14, "edge_tx_count",
        64'(tx_cnt - n0), 64'd14);
    chk(busy == 1'b1, "edge_busy", 64'(busy), 64'd1);
    src_abort = 1'b1;
    do_reset();

    // randomized job mix
    for (int j = 0; j < 8; j++) begin
      ll = 8'($urandom_range(0, 55));
      nd = 4'($urandom_range(0, 15));
      nl = 12'($urandom_range(0, 2));
      tx_busy = $urandom_range(1, 8);
      if (job_ok(ll, nd))
        run_job(ll, nl, nd, $urandom_range(0, 3),
                {$urandom, $urandom}, 8);
      else
        bad_start(ll, nl, nd);
    end

    repeat (10) @(negedge sysclk);
    chk(ovl == 0, "s_ready_overlap", 64'(ovl), 64'd0);
    chk(exp_tx.size() == 0, "tx_queue_empty",
        64'(exp_tx.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/day3_host_link.md
Name: day3_host_link

Overview:
- Host-side end of the day3 UART job protocol; the peer of the line-processing solver.
- Frames one job: 4-byte header (0xAA, line length, line count, digit count), then packed-BCD line bytes taken from a byte stream.
- Collects the solver's 8-byte big-endian result and presents it as a 64-bit word.
- Sits on sysclk between a job source (BRAM reader or loopback bench) and the ua_tx/ua_rx byte interfaces.

Parameters:
MAX_LINE_BYTES, 50, largest legal line length in bytes (solver line buffer holds 100 digits).
TIMEOUT_CYCLES, 100_000_000, sysclk cycles allowed between consecutive response bytes, and from the last tx byte to the first response byte.

Ports:
sysclk  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle job request; sampled only in IDLE
line_len  input  8  bytes per line (2 BCD digits per byte)
n_lines  input  12  number of lines
n_digits  input  4  digits selected per line
s_data  input  8  line byte, high nibble is the more significant digit
s_valid  input  1  s_data valid
s_ready  output  1  line byte accepted when s_valid & s_ready
tx_data  output  8  byte to ua_tx
tx_xmit  output  1  transmit request to ua_tx
tx_ready  input  1  ua_tx idle
rx_data  input  8  byte from ua_rx
rx_recd  input  1  ua_rx byte-received flag
rx_rst  output  1  ua_rx reset, used to acknowledge a byte
busy  output  1  job in progress
result  output  64  last received result
result_valid  output  1  one-cycle pulse when result updates
error  output  1  sticky error flag; cleared by the next accepted start or by reset

Behaviour:
- Reset values:
  - s_ready, tx_xmit, busy, result_valid, error = 0.
  - rx_rst = 1 for the reset cycle.
  - tx_data = 0, result = 0.
  - State = IDLE.
- Reset mid-operation aborts the job immediately.
  - No further tx_xmit is issued. A byte already handed to ua_tx may still complete on the line.
  - Partially collected response is discarded.
- Parameter check, performed on start in IDLE:
  - Invalid if line_len == 0, line_len > MAX_LINE_BYTES, n_digits == 0, or n_digits > 2*line_len.
  - On an invalid job: go to ERR, set error, transmit nothing.
  - n_lines == 0 is legal: header only, then wait for the response (expected 0).
- Accepted start: latch all three parameters, clear error, set busy, go to HDR.
- Header bytes, in send order: 0xAA, line_len, n_lines[11:4], {n_lines[3:0], n_digits}.
- LINE state: transfers line_len*n_lines bytes from s_data.
  - Uses a 20-bit total counter.
  - s_ready = 1 only while a byte slot is free, i.e. no byte is in flight to ua_tx.
  - Each accepted byte goes straight to the tx sub-machine.
- Tx sub-machine, per byte:
  - T_IDLE: wait for tx_ready = 1.
  - Drive tx_data and assert tx_xmit.
  - Hold tx_xmit until tx_ready = 0 is observed (ua_tx runs on com_clk), then deassert.
  - The byte is complete on that transition.
  - tx_data is stable from tx_xmit rise until tx_ready falls.
- RESP state:
  - While rx_recd = 1 and rx_rst = 0: shift rx_data into a 64-bit accumulator (first byte = bits 63:56), increment a 3-bit count, pulse rx_rst = 1 for one cycle.
  - Otherwise rx_rst = 0.
  - rx_rst is held at 0 through HDR and LINE so that ua_rx stays armed.
- After the 8th byte:
  - result <= accumulator and result_valid = 1 on the next cycle.
  - busy drops the same cycle; return to IDLE.
- Timeout: a 32-bit watchdog runs in RESP and restarts on every received byte. Reaching TIMEOUT_CYCLES → ERR, error = 1, result unchanged.
- ERR: one cycle, then IDLE; busy = 0.
- start while busy is ignored.
- s_valid gaps stall LINE indefinitely with no timeout. Bytes presented while s_ready = 0 are not consumed.
- Response bytes arriving before RESP are ignored and not acknowledged.
- Latency: first tx_xmit asserts 2 cycles after an accepted start when tx_ready = 1.

Test Plan:
- Nominal job: line_len=2, n_lines=2, n_digits=2; lines 0x98 0x76 and 0x12 0x34; responder returns 00 00 00 00 00 00 00 C6 → tx sequence AA 02 00 22 98 76 12 34; result = 0x00000000000000C6; result_valid high for exactly 1 cycle; busy low after.
- Stream stalls: s_valid low for 50 cycles between every line byte; tx_ready model has a 300-cycle busy time → identical tx byte sequence, no duplicated or dropped bytes, s_ready never high while tx_xmit pending.
- Invalid parameters: start with line_len=51, then n_digits=5 with line_len=2 → error = 1, zero tx_xmit pulses, busy low within 2 cycles; next valid start clears error.
- Response timeout: TIMEOUT_CYCLES=1000; responder sends 3 bytes then stops → error = 1 exactly 1000 cycles after the 3rd byte; result keeps its previous value; no result_valid pulse.
- Reset mid-LINE: assert reset after the 5th line byte of a 3-line job → all outputs at reset values next cycle; a fresh job then completes with the correct header and result.
- Edge values: n_lines=0xFFF, n_digits=15, line_len=50, one start pulse while busy → header AA 32 FF FF; the extra start is ignored; the byte count equals 4 + 50*4095.
